// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer owning the HI/LO registers.
// mult/multu use a WIDTH-step shift-add loop, div/divu use a WIDTH-step
// restoring divide on operand magnitudes. A final FIX cycle applies the
// sign corrections before HI/LO are written.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             flush,
  input  logic             mfhi,
  input  logic             mflo,
  input  logic             mthi,
  input  logic             mtlo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done
);

  localparam logic [4:0] OP_MULT  = 5'b10011;
  localparam logic [4:0] OP_MULTU = 5'b10101;
  localparam logic [4:0] OP_DIV   = 5'b10110;
  localparam logic [4:0] OP_DIVU  = 5'b10111;

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Latched operation context
  logic             is_div;
  logic             neg_res;   // quotient / product must be negated
  logic             neg_rem;   // remainder takes the (negative) dividend sign
  logic             div0;      // divisor was zero
  logic [CW-1:0]    count;

  // Iteration registers: {acc_hi, acc_lo} is the product accumulator for
  // mult, and {remainder, quotient} for div. opnd_b is the multiplicand or
  // the divisor magnitude.
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opnd_b;

  // Decode outputs
  logic             op_valid;
  logic             op_div;
  logic             op_signed;
  logic             accept;

  // Operand magnitudes at issue
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  // One iteration of the loop
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;
  logic             rem_fits;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  // Sign-corrected results written during FIX
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  // Decode the alucontrol code into kind and signedness.
  // NOTE: every output of an always_comb gets a default first so no path
  // leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    op_valid  = 1'b0;
    op_div    = 1'b0;
    op_signed = 1'b0;
    case (op)
      OP_MULT:  begin op_valid = 1'b1; op_signed = 1'b1; end
      OP_MULTU: begin op_valid = 1'b1; end
      OP_DIV:   begin op_valid = 1'b1; op_div = 1'b1; op_signed = 1'b1; end
      OP_DIVU:  begin op_valid = 1'b1; op_div = 1'b1; end
      default:  ;
    endcase
  end

  assign accept = (state == IDLE) && start && op_valid && !flush;

  // Signed ops iterate on magnitudes; the sign is restored in FIX.
  always_comb begin
    mag_a = srca;
    mag_b = srcb;
    if (op_signed && srca[WIDTH-1]) mag_a = -srca;
    if (op_signed && srcb[WIDTH-1]) mag_b = -srcb;
  end

  // Single loop step for both shift-add multiply and restoring divide.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : '0);
    rem_shift = {acc_hi, acc_lo[WIDTH-1]};
    rem_fits  = rem_shift >= {1'b0, opnd_b};
    rem_diff  = rem_shift - {1'b0, opnd_b};
    if (is_div) begin
      step_hi = rem_fits ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], rem_fits};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  // Sign correction of the finished magnitudes. A zero divisor makes the
  // quotient all ones; the remainder then equals |srca| and the dividend
  // sign rule hands back srca unchanged.
  always_comb begin
    prod = {acc_hi, acc_lo};
    if (neg_res) prod = -prod;
    if (is_div) begin
      fix_hi = neg_rem ? -acc_hi : acc_hi;
      if (div0)         fix_lo = '1;
      else if (neg_res) fix_lo = -acc_lo;
      else              fix_lo = acc_lo;
    end else begin
      fix_hi = prod[2*WIDTH-1:WIDTH];
      fix_lo = prod[WIDTH-1:0];
    end
  end

  // State register.
  // NOTE: sequential state is always assigned with non-blocking (<=) so all
  // flops update together at the edge regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: flush aborts from any busy state.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = CALC;
      CALC: begin
        if (flush)                  state_next = IDLE;
        else if (count == CW'(1))   state_next = FIX;
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs derived from the state.
  always_comb begin
    busy  = (state != IDLE);
    stall = busy && (start || mfhi || mflo || mthi || mtlo);
  end

  // Operand capture at issue and one loop iteration per CALC cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
      count   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      opnd_b  <= '0;
    end else if (accept) begin
      is_div  <= op_div;
      neg_res <= op_signed && (srca[WIDTH-1] ^ srcb[WIDTH-1]);
      neg_rem <= op_signed && op_div && srca[WIDTH-1];
      div0    <= op_div && (srcb == '0);
      count   <= CW'(WIDTH);
      acc_hi  <= '0;
      acc_lo  <= op_div ? mag_a : mag_b;
      opnd_b  <= op_div ? mag_b : mag_a;
    end else if (state == CALC && !flush) begin
      count   <= count - CW'(1);
      acc_hi  <= step_hi;
      acc_lo  <= step_lo;
    end
  end

  // HI/LO update: op results at the end of FIX, mthi/mtlo only when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == FIX && !flush) begin
        hi   <= fix_hi;
        lo   <= fix_lo;
        done <= 1'b1;
      end else if (state == IDLE) begin
        if (mthi) hi <= srca;
        if (mtlo) lo <= srca;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: stimulus pushes reference results into
// a queue, an independent monitor compares HI/LO on every done pulse.
module tb_muldiv_seq;

  localparam int W = 32;

  localparam logic [4:0] OP_MULT  = 5'b10011;
  localparam logic [4:0] OP_MULTU = 5'b10101;
  localparam logic [4:0] OP_DIV   = 5'b10110;
  localparam logic [4:0] OP_DIVU  = 5'b10111;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [4:0]   op = '0;
  logic [W-1:0] srca = '0;
  logic [W-1:0] srcb = '0;
  logic         flush = 1'b0;
  logic         mfhi = 1'b0;
  logic         mflo = 1'b0;
  logic         mthi = 1'b0;
  logic         mtlo = 1'b0;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         stall;
  logic         done;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } res_t;

  res_t         exp_q[$];
  int           n_checks = 0;
  int           n_pass = 0;
  logic [W-1:0] mdl_hi = '0;
  logic [W-1:0] mdl_lo = '0;

  muldiv_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .srca  (srca),
    .srcb  (srcb),
    .flush (flush),
    .mfhi  (mfhi),
    .mflo  (mflo),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .stall (stall),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: plain MIPS HI/LO arithmetic on 32/64-bit integers.
  function automatic res_t model(input logic [4:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    res_t    r;
    int      sa;
    int      sb;
    longint  sp;
    logic [63:0] up;
    sa = a;
    sb = b;
    r  = '0;
    case (o)
      OP_MULT: begin
        sp = longint'(sa) * longint'(sb);
        r  = sp;
      end
      OP_MULTU: begin
        up = {32'b0, a} * {32'b0, b};
        r  = up;
      end
      OP_DIV: begin
        if (b == 0) begin
          r.hi = a; r.lo = '1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          r.hi = '0; r.lo = 32'h8000_0000;
        end else begin
          r.lo = sa / sb;
          r.hi = sa % sb;
        end
      end
      default: begin
        if (b == 0) begin
          r.hi = a; r.lo = '1;
        end else begin
          r.lo = a / b;
          r.hi = a % b;
        end
      end
    endcase
    return r;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding result.
  always @(negedge clk) begin
    if (reset && done) begin
      if (exp_q.size() == 0) begin
        check("done_without_op", 64'(done), 64'd0);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        check("result_hi", 64'(hi), 64'(e.hi));
        check("result_lo", 64'(lo), 64'(e.lo));
        mdl_hi = e.hi;
        mdl_lo = e.lo;
      end
    end
  end

  // Present an op for one cycle; returns on the negedge after the issue edge.
  task automatic issue(input logic [4:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit push);
    @(negedge clk);
    start = 1'b1; op = o; srca = a; srcb = b;
    if (push) exp_q.push_back(model(o, a, b));
    @(negedge clk);
    start = 1'b0; op = '0; srca = $urandom; srcb = $urandom;
  endtask

  // Issue an op and measure cycles until done; latency counted from the issue edge.
  task automatic run_op(input logic [4:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input string name);
    int n;
    issue(o, a, b, 1'b1);
    n = 1;
    check({name, "_busy"}, 64'(busy), 64'd1);
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, "_latency"}, 64'(n), 64'(W + 2));
    check({name, "_busy_end"}, 64'(busy), 64'd0);
    @(negedge clk);
    check({name, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    logic [4:0] ops [4];
    int n;
    ops[0] = OP_MULT; ops[1] = OP_MULTU; ops[2] = OP_DIV; ops[3] = OP_DIVU;

    // Reset state
    #12;
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Directed arithmetic with latency checks
    run_op(OP_MULT,  32'hFFFF_FFFF, 32'h0000_0002, "mult");
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, "multu");
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, "div_neg");
    run_op(OP_DIVU,  32'd100,       32'd7,         "divu");
    run_op(OP_DIV,   32'h0000_1234, 32'h0000_0000, "div_zero");
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(OP_DIVU,  32'h8765_4321, 32'h0000_0000, "divu_zero");
    run_op(OP_DIV,   32'h8000_0001, 32'h7FFF_FFFF, "div_big");

    // mflo one cycle after issue stalls until the result lands; mthi while
    // busy must be ignored.
    issue(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1);
    mflo = 1'b1; mthi = 1'b1; srca = 32'hDEAD_BEEF;
    #1;
    check("stall_mflo", 64'(stall), 64'd1);
    @(negedge clk);
    mthi = 1'b0;
    n = 2;
    while (stall && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("stall_len", 64'(n), 64'(W + 2));
    check("stall_lo", 64'(lo), 64'hFFFF_FFFD);
    check("stall_hi", 64'(hi), 64'hFFFF_FFFF);
    mflo = 1'b0;
    @(negedge clk);

    // Flush mid-op: back to idle, HI/LO untouched, no done afterwards.
    issue(OP_DIVU, 32'd1000, 32'd3, 1'b0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_hilo", {hi, lo}, {mdl_hi, mdl_lo});
    repeat (40) @(negedge clk);
    check("flush_hilo_late", {hi, lo}, {mdl_hi, mdl_lo});

    // Invalid op code with start is ignored.
    issue(5'b10100, 32'd5, 32'd6, 1'b0);
    check("invalid_op_busy", 64'(busy), 64'd0);

    // flush in IDLE wins over start.
    @(negedge clk);
    start = 1'b1; op = OP_MULT; srca = 32'd3; srcb = 32'd4; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_idle_busy", 64'(busy), 64'd0);

    // mthi / mtlo in IDLE
    mthi = 1'b1; srca = 32'hCAFE_0001;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b1; srca = 32'h0BAD_F00D;
    check("mthi", 64'(hi), 64'hCAFE_0001);
    @(negedge clk);
    mtlo = 1'b0;
    check("mtlo", 64'(lo), 64'h0BAD_F00D);
    mdl_hi = 32'hCAFE_0001; mdl_lo = 32'h0BAD_F00D;

    // Reset in the middle of an op
    issue(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    mdl_hi = '0; mdl_lo = '0;
    @(negedge clk);
    reset = 1'b1;

    // Randomized ops, with some small operands and zero divisors mixed in.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [4:0]   o;
      o = ops[$urandom_range(3)];
      a = $urandom;
      b = $urandom;
      case ($urandom_range(4))
        0: b = b & 32'h0000_00FF;
        1: a = a & 32'h0000_FFFF;
        2: if (i % 5 == 0) b = '0;
        default: ;
      endcase
      issue(o, a, b, 1'b1);
      n = 1;
      while (!done && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("rand_latency", 64'(n), 64'(W + 2));
    end

    @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
